// File: rtl/fpu_mul_pkg.sv
// Shared definitions for schedulers that front the pipelined fpu_mul.
package fpu_mul_pkg;

  localparam int FP_W            = 64;  // operand width
  localparam int PROD_W          = 56;  // fpu_mul product_7 width
  localparam int EXP_W           = 12;  // fpu_mul exponent_5 width
  localparam int MUL_LATENCY_DEF = 10;  // enabled edges from operand capture to result
  localparam int TRK_ID_W        = 3;   // wide enough for up to 8 requesters

  // One tracker slot per multiplier pipeline stage.
  typedef struct packed {
    logic                valid;
    logic [TRK_ID_W-1:0] id;
  } trk_entry_t;

endpackage

// File: rtl/fpu_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps mod N.
// Reusable in front of any shared FPU unit.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  // First requesting index at or after ptr wins; no grant when en is low.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
      idx = sum[ID_W-1:0];
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_mul_sched.sv
// Shares one pipelined fpu_mul among NUM_REQ requesters. A tracker shift
// register, advanced by the same enable as the multiplier, carries the
// requester ID of each operation so the result can be tagged on exit.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both 1. Requesters hold req_valid and operands stable until accepted;
// the result port holds res_* stable while res_valid & ~res_ready.
module fpu_mul_sched
  import fpu_mul_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_opa,
  input  logic [NUM_REQ*FP_W-1:0] req_opb,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    mul_enable,
  output logic [FP_W-1:0]         mul_opa,
  output logic [FP_W-1:0]         mul_opb,
  input  logic                    mul_sign,
  input  logic [PROD_W-1:0]       mul_product,
  input  logic [EXP_W-1:0]        mul_exponent,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ID_W-1:0]         res_id,
  output logic                    res_sign,
  output logic [PROD_W-1:0]       res_product,
  output logic [EXP_W-1:0]        res_exponent,
  output logic [3:0]              inflight
);

  trk_entry_t      trk_q [MUL_LATENCY];
  trk_entry_t      tail;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] grant_id;
  logic [3:0]      inflight_q;
  logic            stall;
  logic            busy;
  logic            granted;
  logic            consumed;
  logic            unused_id_hi;

  // Tail entry lines up with the data currently on the mul_* result inputs.
  assign tail         = trk_q[MUL_LATENCY-1];
  assign unused_id_hi = ^tail.id;

  // Idle/run/stall are derived here rather than encoded in a state register.
  assign stall      = tail.valid & ~res_ready;
  assign busy       = (|req_valid) | (inflight_q != 4'd0);
  assign mul_enable = ~rst & ~stall & busy;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .en       (mul_enable),
    .grant    (req_ready),
    .grant_id (grant_id)
  );

  assign granted  = |req_ready;
  assign ptr_next = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);

  // Operand mux from the one-hot grant; zero when nothing is granted.
  always_comb begin
    mul_opa = '0;
    mul_opb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mul_opa = mul_opa | (req_opa[FP_W*i +: FP_W] & {FP_W{req_ready[i]}});
      mul_opb = mul_opb | (req_opb[FP_W*i +: FP_W] & {FP_W{req_ready[i]}});
    end
  end

  // Result port: tag from the tracker tail, data straight from the multiplier.
  assign res_valid    = tail.valid & ~rst;
  assign res_id       = tail.id[ID_W-1:0];
  assign res_sign     = mul_sign;
  assign res_product  = mul_product;
  assign res_exponent = mul_exponent;
  assign consumed     = res_valid & res_ready;
  assign inflight     = inflight_q;

  // Tracker shift, round-robin pointer and in-flight count; reset discards all work.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MUL_LATENCY; k++) trk_q[k] <= '0;
      ptr_q      <= '0;
      inflight_q <= 4'd0;
    end else begin
      if (mul_enable) begin
        for (int k = MUL_LATENCY-1; k > 0; k--) trk_q[k] <= trk_q[k-1];
        trk_q[0].valid <= granted;
        trk_q[0].id    <= granted ? TRK_ID_W'(grant_id) : '0;
      end
      if (granted) ptr_q <= ptr_next;
      case ({granted, consumed})
        2'b10:   inflight_q <= inflight_q + 4'd1;
        2'b01:   inflight_q <= inflight_q - 4'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mul_sched.sv
// Bench for fpu_mul_sched with a behavioural enable-gated multiplier model.
module tb_fpu_mul_sched;

  localparam int NR  = 4;
  localparam int LAT = 10;
  localparam int EW  = 2 + 69 + 32;  // {id, {sign,exp,prod}, accept cycle}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR*64-1:0] req_opa, req_opb;
  logic [NR-1:0]    req_ready;
  logic             mul_enable;
  logic [63:0]      mul_opa, mul_opb;
  logic             mul_sign;
  logic [55:0]      mul_product;
  logic [11:0]      mul_exponent;
  logic             res_valid, res_ready;
  logic [1:0]       res_id;
  logic             res_sign;
  logic [55:0]      res_product;
  logic [11:0]      res_exponent;
  logic [3:0]       inflight;

  fpu_mul_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_opa(req_opa), .req_opb(req_opb), .req_ready(req_ready),
    .mul_enable(mul_enable), .mul_opa(mul_opa), .mul_opb(mul_opb),
    .mul_sign(mul_sign), .mul_product(mul_product), .mul_exponent(mul_exponent),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sign(res_sign), .res_product(res_product), .res_exponent(res_exponent),
    .inflight(inflight)
  );

  // Reference multiply: {sign, exponent, top 56 bits of mantissa product}.
  function automatic logic [68:0] fmul(input logic [63:0] a, input logic [63:0] b);
    logic [105:0] p;
    logic [11:0]  e;
    logic         s;
    s = a[63] ^ b[63];
    if (a[62:0] == 63'd0 || b[62:0] == 63'd0) return {s, 12'd0, 56'd0};
    p = {53'd0, 1'b1, a[51:0]} * {53'd0, 1'b1, b[51:0]};
    e = {1'b0, a[62:52]} + {1'b0, b[62:52]} - 12'd1023;
    return {s, e, p[105:50]};
  endfunction

  // Stand-in for fpu_mul: LAT stages, frozen when enable is low.
  logic [68:0] pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else if (mul_enable) begin
      for (int k = LAT-1; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= fmul(mul_opa, mul_opb);
    end
  end
  assign {mul_sign, mul_exponent, mul_product} = pipe[LAT-1];

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [EW-1:0]  exp_q[$];
  logic [127:0]   op_q [NR][$];
  logic [NR-1:0]  acc_flags = '0;
  int m_ptr = 0, n_acc = 0, n_cons = 0, last_stall = -1, max_inflight = 0;
  int tp_first_acc = -1, tp_last_acc = 0, tp_n_acc = 0;
  int tp_first_res = -1, tp_last_res = 0, tp_n_res = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return NR'(1) << ((p + k) % NR);
    end
    return '0;
  endfunction

  // ---------------- monitor (all DUT sampling at negedge) ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mul_enable", mul_enable, 0);
      chk("rst_res_valid", res_valid, 0);
      exp_q.delete();
      n_acc = 0; n_cons = 0; m_ptr = 0; acc_flags = '0;
    end else begin
      chk("inflight", inflight, n_acc - n_cons);
      if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
      if (req_ready != '0) chk("rr_grant", req_ready, rr_pick(req_valid, m_ptr));
      if (res_ready && req_valid != '0) chk("grant_present", req_ready != '0, 1);
      acc_flags = req_valid & req_ready;
      for (int i = 0; i < NR; i++) begin
        if (acc_flags[i]) begin
          exp_q.push_back({2'(i), fmul(req_opa[64*i +: 64], req_opb[64*i +: 64]), 32'(cyc)});
          m_ptr = (i + 1) % NR;
          n_acc++;
          if (i == 2) begin
            if (tp_first_acc < 0) tp_first_acc = cyc;
            tp_last_acc = cyc;
            tp_n_acc++;
          end
        end
      end
      if (res_valid && !res_ready) last_stall = cyc;
      if (res_valid && res_ready) begin
        n_cons++;
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_result: got id %0d, expected none (cycle %0d)", res_id, cyc);
        end else begin
          logic [EW-1:0] e;
          int e_cyc;
          e = exp_q.pop_front();
          e_cyc = int'(e[31:0]);
          chk("res_id", res_id, e[102:101]);
          chk("res_sign", res_sign, e[100]);
          chk("res_exponent", res_exponent, e[99:88]);
          chk("res_product", res_product, e[87:32]);
          if (e_cyc > last_stall) chk("latency", cyc - e_cyc, LAT);
          if (e[102:101] == 2'd2) begin
            if (tp_first_res < 0) tp_first_res = cyc;
            tp_last_res = cyc;
            tp_n_res++;
          end
        end
      end
    end
  end

  // ---------------- requester driver ----------------
  // Holds each request until accepted, then presents the next queued op.
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc_flags[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && op_q[i].size() > 0) begin
        logic [127:0] op;
        op = op_q[i].pop_front();
        req_opa[64*i +: 64] = op[127:64];
        req_opb[64*i +: 64] = op[63:0];
        req_valid[i] = 1'b1;
      end
    end
    acc_flags = '0;
  end

  function automatic logic [63:0] rand_fp();
    return {$urandom_range(1, 0) == 1, 11'($urandom_range(1100, 950)), $urandom(), 20'($urandom())};
  endfunction

  task automatic push_rand(input int i);
    op_q[i].push_back({rand_fp(), rand_fp()});
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int t = 0; t < 800 && !done; t++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && req_valid == '0 && op_q[0].size() == 0 && op_q[1].size() == 0 &&
          op_q[2].size() == 0 && op_q[3].size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL %s_drain: got timeout, expected empty pipeline", name);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [70:0] snap;
    bit          seen;
    int          base;
    rst = 1'b1; res_ready = 1'b1; req_valid = '0; req_opa = '0; req_opb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_mul_enable", mul_enable, 0);
    chk("idle_inflight", inflight, 0);

    // Single op: 1.5 * -2.0 on requester 0
    op_q[0].push_back({64'h3FF8000000000000, 64'hC000000000000000});
    wait_drain("single");

    // Contention: all four requesters from reset
    reset_pulse();
    for (int j = 0; j < 3; j++) for (int i = 0; i < NR; i++) push_rand(i);
    wait_drain("contention");

    // Backpressure: stall 5 cycles at the first result
    for (int j = 0; j < 3; j++) push_rand(1);
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    chk("bp_first_result_seen", seen, 1);
    snap = {res_id, res_sign, res_product, res_exponent};
    res_ready = 1'b0;
    push_rand(3); push_rand(3);
    repeat (5) begin
      @(negedge clk);
      chk("bp_mul_enable", mul_enable, 0);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_stable", {res_id, res_sign, res_product, res_exponent}, snap);
      @(posedge clk);
    end
    #1 res_ready = 1'b1;
    wait_drain("backpressure");

    // Throughput: 20 back-to-back ops on requester 2
    tp_first_acc = -1; tp_n_acc = 0; tp_first_res = -1; tp_n_res = 0; max_inflight = 0;
    for (int j = 0; j < 20; j++) push_rand(2);
    wait_drain("throughput");
    chk("tp_accepts", tp_n_acc, 20);
    chk("tp_accept_span", tp_last_acc - tp_first_acc, 19);
    chk("tp_results", tp_n_res, 20);
    chk("tp_result_span", tp_last_res - tp_first_res, 19);
    chk("tp_inflight_max", max_inflight, 10);

    // Reset mid-stream with 6 ops in flight from requester 1
    base = n_acc;
    for (int j = 0; j < 6; j++) push_rand(1);
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(posedge clk); #1;
      if (n_acc - base == 6) seen = 1'b1;
    end
    chk("mid_six_accepted", seen, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_inflight", inflight, 0);
    chk("mid_res_valid", res_valid, 0);
    repeat (15) begin
      @(negedge clk);
      chk("mid_no_stale", res_valid, 0);
    end
    push_rand(2); push_rand(0);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (req_ready != '0) seen = 1'b1;
    end
    chk("mid_ptr_restart", req_ready, 4'b0001);
    wait_drain("midreset");

    // Zero operand on requester 1
    op_q[1].push_back({64'h0, 64'h4000000000000000});
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    chk("zero_seen", seen, 1);
    chk("zero_exponent", res_exponent, 0);
    chk("zero_id", res_id, 1);
    wait_drain("zero");

    // Random traffic with random backpressure
    for (int t = 0; t < 80; t++) begin
      @(posedge clk); #1;
      res_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(1, 0) == 1) push_rand(int'($urandom_range(NR-1, 0)));
    end
    @(posedge clk); #1 res_ready = 1'b1;
    wait_drain("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_mul_sched.md
Name: fpu_mul_sched

Overview:
Scheduler that shares one pipelined fpu_mul instance among NUM_REQ requesters. It grants requests round-robin and drives the multiplier's enable and operands. It tracks each in-flight operation's requester ID in a shift register aligned with the multiplier pipeline. Results return on a single valid/ready port tagged with that ID; downstream backpressure freezes the whole multiplier pipeline through its enable.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width, equal to clog2(NUM_REQ)
MUL_LATENCY, 10, enabled clock edges from operand capture to a valid result on mul_product/mul_exponent/mul_sign

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  NUM_REQ  per-requester request
req_opa  in  NUM_REQ*64  per-requester operand A (slice i = [64*i+63:64*i])
req_opb  in  NUM_REQ*64  per-requester operand B
req_ready  out  NUM_REQ  one-hot grant; operands accepted on an edge where valid&ready
mul_enable  out  1  to fpu_mul enable
mul_opa  out  64  to fpu_mul opa
mul_opb  out  64  to fpu_mul opb
mul_sign  in  1  from fpu_mul sign
mul_product  in  56  from fpu_mul product_7
mul_exponent  in  12  from fpu_mul exponent_5
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_id  out  ID_W  requester ID of the result
res_sign  out  1  result sign
res_product  out  56  result mantissa field
res_exponent  out  12  result exponent
inflight  out  4  number of valid tracker entries (0..MUL_LATENCY)

Behaviour:
- Tracker: MUL_LATENCY entries of {valid, id}. Entry 0 is written on the issue edge. The tail, entry MUL_LATENCY-1, corresponds to data currently on the mul_* result inputs.
- stall = tail.valid & ~res_ready.
- mul_enable = ~rst & ~stall & (|req_valid | inflight != 0). The multiplier's enable is decided as fixed.
- The tracker shifts only on edges where mul_enable=1. Entry 0 takes {granted, grant_id}, or {0, x} if no grant.
- Arbitration, combinational: grant only when mul_enable=1 and some req_valid. Search order starts at pointer ptr, incrementing mod NUM_REQ; the first valid requester wins. req_ready is one-hot or zero.
- mul_opa/mul_opb mux from the winner; they are 0 when there is no grant.
- ptr (ID_W bits) resets to 0. On a grant to requester i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- Requesters hold req_valid and operands stable until accepted. The block does not check for retraction.
- res_valid = tail.valid. res_id = tail.id. res_sign/res_product/res_exponent pass mul_* through combinationally.
- While stalled the multiplier is frozen, so the result is held stable until res_ready.
- Throughput: one issue per cycle when unstalled. Latency from accept edge to res_valid is MUL_LATENCY enabled edges; minimum MUL_LATENCY cycles.
- Simultaneous accept and result consume on the same edge: both occur, and inflight is unchanged.
- inflight: +1 on issue, -1 on a consumed result, unchanged if both or neither.
- Empty and idle: mul_enable=0 and all tracker state holds.
- Reset, including mid-operation: all tracker valids 0, ptr 0, inflight 0. While rst is high: req_ready=0, mul_enable=0, res_valid=0. All in-flight operations are discarded, with no result output. The multiplier is reset from the same rst.
- No internal FSM beyond tracker, pointer and counter. States are effectively IDLE (inflight 0, no req), RUN, STALL (tail valid, res_ready 0) and are derived, not encoded.

Decomposition:
- Package fpu_mul_pkg: FP_W=64, PROD_W=56, EXP_W=12, MUL_LATENCY default, tracker entry struct {valid, id}.
- Sub-module rr_arbiter (NUM_REQ): inputs req, ptr, en; outputs one-hot grant and grant_id. It is reusable for other shared FPU units.

Test Plan:
- Bench setup for all scenarios: real fpu_mul, MUL_LATENCY=10, res_ready=1 unless stated.
- Single op: req0 opa=0x3FF8000000000000, opb=0xC000000000000000. Required: res_valid exactly 10 cycles after accept; res_id=0; res_sign=1; product/exponent bit-identical to standalone fpu_mul for the same operands.
- Contention: all four req_valid high from reset, each with distinct operands. Required: grants in order 0,1,2,3,0… on consecutive cycles; results return in the same ID order, one per cycle, each matching its operands.
- Backpressure: 3 ops in flight, drop res_ready for 5 cycles when the first result appears. Required: mul_enable=0 and res_* stable for those 5 cycles; req_ready=0; then all 3 results delivered with no loss or duplication.
- Throughput: req2 streams 20 ops back-to-back. Required: req_ready high every cycle; 20 results on consecutive cycles; inflight saturates at 10.
- Reset mid-stream: rst for 1 cycle with 6 ops in flight. Required: inflight=0 and res_valid=0 after reset; no stale result appears in the next 15 cycles; ptr restarts at 0.
- Zero operand: opa=0, opb=0x4000000000000000. Required: res_exponent=0 and res_id correct.
